// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the memory-stage load/store unit:
//   - RV32I funct3 width/sign codes (stores reuse the LB/LH/LW encodings)
//   - lsu_state_t : controller states IDLE, REQ, WAIT, DONE
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane logic for the load/store unit.
// Ports:
//   funct3     in  3   width/sign code of the access
//   off        in  2   byte offset within the word (addr[1:0])
//   store_data in  32  store source register value
//   read_word  in  32  word returned by data memory
//   wdata      out 32  lane-replicated store data
//   wstrb      out 4   byte enables for the store
//   load_data  out 32  extracted and sign/zero-extended load value
//   misaligned out 1   access crosses its natural alignment
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: funct3[1:0] alone selects the width; any width code
    // other than byte/half is handled as a full word.
    always_comb begin
        wdata      = store_data;
        wstrb      = 4'b1111;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << off;
            end
            2'b01: begin
                wdata      = {2{store_data[15:0]}};
                wstrb      = 4'b0011 << off;
                misaligned = off[0];
            end
            default: begin
                misaligned = (off != 2'b00);
            end
        endcase
    end

    // Load side: undefined funct3 codes fall through to a full word.
    always_comb begin
        byte_sel = 8'(read_word >> {off, 3'b000});
        half_sel = off[1] ? read_word[31:16] : read_word[15:0];
        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {24'b0, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data = {16'b0, half_sel};
            default: load_data = read_word;
        endcase
    end

endmodule

// File: rtl/mem_load_store_unit.sv
// ---------------------------------------------------------------------------
// mem_load_store_unit
// Memory-stage data-port controller: owns the data-memory bus, aligns store
// data/strobes, runs the valid/ready request and rvalid response handshake,
// and produces the registered, extended load value ReadDataW.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   MemReadM, MemWriteM        load / store present in M stage
//   Funct3M                    width/sign code
//   AluResultM                 effective address
//   WriteDataM                 store source value
//   StallM                     freeze F/D/E/M registers
//   ReadDataW, LoadValidW      load result and its one-cycle update pulse
//   MisalignM, BusErrM         one-cycle error pulses
//   dmem_req_valid/ready, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb
//   dmem_rvalid, dmem_rdata    data-memory bus
// ---------------------------------------------------------------------------
module mem_load_store_unit
    import lsu_pkg::*;
#(
    parameter int          XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] AluResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic            StallM,
    output logic [XLEN-1:0] ReadDataW,
    output logic            LoadValidW,
    output logic            MisalignM,
    output logic            BusErrM,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata
);

    lsu_state_t  state, state_next;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] wd_cnt;

    logic        access;
    logic        latch_req;
    logic        load_fire;
    logic        mis_fire;
    logic        berr_fire;
    logic        wd_expired;

    logic [2:0]  align_funct3;
    logic [1:0]  align_off;
    logic [31:0] align_wdata;
    logic [3:0]  align_wstrb;
    logic [31:0] align_load;
    logic        align_mis;

    assign access     = MemReadM | MemWriteM;
    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == TIMEOUT - 1);

    // In IDLE the lane logic looks at the live M-stage access so it can be
    // latched; afterwards it sees the latched access for load extraction.
    assign align_funct3 = (state == IDLE) ? Funct3M : funct3_q;
    assign align_off    = (state == IDLE) ? AluResultM[1:0] : off_q;

    lsu_align u_align (
        .funct3     (align_funct3),
        .off        (align_off),
        .store_data (WriteDataM),
        .read_word  (dmem_rdata),
        .wdata      (align_wdata),
        .wstrb      (align_wstrb),
        .load_data  (align_load),
        .misaligned (align_mis)
    );

    assign dmem_req_valid = (state == REQ);

    // Next-state and stall logic; a ready in the same cycle the watchdog
    // expires still completes the access normally.
    always_comb begin
        state_next = state;
        StallM     = 1'b0;
        latch_req  = 1'b0;
        load_fire  = 1'b0;
        mis_fire   = 1'b0;
        berr_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    StallM = 1'b1;
                    if (align_mis) begin
                        mis_fire   = 1'b1;
                        state_next = DONE;
                    end else begin
                        latch_req  = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                StallM = 1'b1;
                if (dmem_req_ready) begin
                    state_next = dmem_we ? DONE : WAIT;
                end else if (wd_expired) begin
                    berr_fire  = 1'b1;
                    state_next = DONE;
                end
            end
            WAIT: begin
                StallM = 1'b1;
                if (dmem_rvalid) begin
                    load_fire  = 1'b1;
                    state_next = DONE;
                end else if (wd_expired) begin
                    berr_fire  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request fields are captured once in IDLE and held until acceptance.
    // A load with MemWriteM also set is a store, so MemWriteM alone picks we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= 4'b0000;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            ReadDataW  <= '0;
            LoadValidW <= 1'b0;
            MisalignM  <= 1'b0;
            BusErrM    <= 1'b0;
        end else begin
            if (latch_req) begin
                dmem_we    <= MemWriteM;
                dmem_addr  <= {AluResultM[31:2], 2'b00};
                dmem_wdata <= MemWriteM ? align_wdata : 32'h0;
                dmem_wstrb <= MemWriteM ? align_wstrb : 4'b0000;
                funct3_q   <= Funct3M;
                off_q      <= AluResultM[1:0];
            end
            if (load_fire) begin
                ReadDataW <= align_load;
            end
            LoadValidW <= load_fire;
            MisalignM  <= mis_fire;
            BusErrM    <= berr_fire;
        end
    end

    // Watchdog restarts on every entry to REQ or WAIT so each phase gets
    // its own TIMEOUT-cycle budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if ((state_next != state) && ((state_next == REQ) || (state_next == WAIT))) begin
            wd_cnt <= '0;
        end else if ((state == REQ) || (state == WAIT)) begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_load_store_unit
// Directed vectors for the load/store unit. Each issued access pushes its
// expected bus request and load result into a queue; a negedge monitor pops
// and compares whenever the DUT presents a request, load, or error pulse.
// A second instance with TIMEOUT=4 exercises the watchdog.
// ---------------------------------------------------------------------------
module tb_mem_load_store_unit;
    import lsu_pkg::*;

    localparam int EV_REQ  = 0;
    localparam int EV_LOAD = 1;
    localparam int EV_MIS  = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] AluResultM, WriteDataM;
    logic        StallM, LoadValidW, MisalignM, BusErrM;
    logic [31:0] ReadDataW;
    logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;

    logic        wd_read;
    logic [2:0]  wd_f3;
    logic [31:0] wd_addr;
    logic        wd_stall, wd_loadvalid, wd_mis, wd_buserr, wd_req_valid, wd_we;
    logic [31:0] wd_readdata, wd_dmem_addr, wd_wdata;
    logic [3:0]  wd_wstrb;

    ev_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_load = 32'h0;

    mem_load_store_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .MemReadM       (MemReadM),
        .MemWriteM      (MemWriteM),
        .Funct3M        (Funct3M),
        .AluResultM     (AluResultM),
        .WriteDataM     (WriteDataM),
        .StallM         (StallM),
        .ReadDataW      (ReadDataW),
        .LoadValidW     (LoadValidW),
        .MisalignM      (MisalignM),
        .BusErrM        (BusErrM),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata)
    );

    mem_load_store_unit #(.TIMEOUT(4)) dut_wd (
        .clk            (clk),
        .rst_n          (rst_n),
        .MemReadM       (wd_read),
        .MemWriteM      (1'b0),
        .Funct3M        (wd_f3),
        .AluResultM     (wd_addr),
        .WriteDataM     (32'h0),
        .StallM         (wd_stall),
        .ReadDataW      (wd_readdata),
        .LoadValidW     (wd_loadvalid),
        .MisalignM      (wd_mis),
        .BusErrM        (wd_buserr),
        .dmem_req_valid (wd_req_valid),
        .dmem_req_ready (1'b0),
        .dmem_we        (wd_we),
        .dmem_addr      (wd_dmem_addr),
        .dmem_wdata     (wd_wdata),
        .dmem_wstrb     (wd_wstrb),
        .dmem_rvalid    (1'b0),
        .dmem_rdata     (32'h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    // Monitor: every observable DUT event must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dmem_req_valid) begin
                if (sb.size() == 0 || sb[0].kind != EV_REQ) begin
                    checkOutput("unexpected_req", 32'(dmem_req_valid), 32'h0);
                end else begin
                    checkOutput("req_addr", dmem_addr, sb[0].addr);
                    checkOutput("req_we", 32'(dmem_we), 32'(sb[0].we));
                    checkOutput("req_wdata", dmem_wdata, sb[0].wdata);
                    checkOutput("req_wstrb", 32'(dmem_wstrb), 32'(sb[0].wstrb));
                    if (dmem_req_ready) void'(sb.pop_front());
                end
            end
            if (LoadValidW) begin
                if (sb.size() == 0 || sb[0].kind != EV_LOAD) begin
                    checkOutput("unexpected_load", 32'(LoadValidW), 32'h0);
                end else begin
                    checkOutput("load_data", ReadDataW, sb[0].rdata);
                    void'(sb.pop_front());
                end
            end
            if (MisalignM) begin
                if (sb.size() == 0 || sb[0].kind != EV_MIS) begin
                    checkOutput("unexpected_misalign", 32'(MisalignM), 32'h0);
                end else begin
                    checkOutput("misalign_no_req", 32'(dmem_req_valid), 32'h0);
                    void'(sb.pop_front());
                end
            end
            if (BusErrM) begin
                checkOutput("unexpected_buserr", 32'(BusErrM), 32'h0);
            end
        end
    end

    // Issues one access, plays the memory side with the given ready/rvalid
    // delays, and checks the IDLE..DONE latency and ReadDataW holding.
    task automatic applyStimulus(
        input logic rd, input logic wr, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] wdata_in, input logic [31:0] rword,
        input int ready_dly, input int rvalid_dly,
        input logic [31:0] exp_addr, input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
        input logic [31:0] exp_load, input int exp_lat, input logic exp_mis);
        ev_t  ev;
        int   cyc, wcnt, rcnt, lat;
        logic accepted, rv_sent, is_load;
        is_load  = rd && !wr;
        ev.kind  = EV_REQ;
        ev.addr  = exp_addr;
        ev.we    = wr;
        ev.wdata = exp_wdata;
        ev.wstrb = exp_wstrb;
        ev.rdata = exp_load;
        @(posedge clk); #1;
        if (exp_mis) begin
            ev.kind = EV_MIS;
            sb.push_back(ev);
        end else begin
            sb.push_back(ev);
            if (is_load) begin
                ev.kind = EV_LOAD;
                sb.push_back(ev);
            end
        end
        MemReadM = rd; MemWriteM = wr; Funct3M = f3;
        AluResultM = addr; WriteDataM = wdata_in; dmem_rdata = rword;
        cyc = 1; lat = 0; wcnt = 0; rcnt = 0; accepted = 0; rv_sent = 0;
        while (lat == 0 && cyc <= 60) begin
            @(negedge clk);
            if (!StallM) begin
                lat = cyc;
            end else begin
                @(posedge clk); #1;
                MemReadM = 1'b0; MemWriteM = 1'b0;
                if (dmem_req_ready) begin
                    accepted = 1'b1;
                    dmem_req_ready = 1'b0;
                end else if (dmem_req_valid) begin
                    if (wcnt >= ready_dly) dmem_req_ready = 1'b1;
                    wcnt++;
                end
                if (dmem_rvalid) begin
                    dmem_rvalid = 1'b0;
                end else if (accepted && is_load && !rv_sent) begin
                    if (rcnt >= rvalid_dly) begin
                        dmem_rvalid = 1'b1;
                        rv_sent = 1'b1;
                    end
                    rcnt++;
                end
                cyc++;
            end
        end
        MemReadM = 1'b0; MemWriteM = 1'b0;
        dmem_req_ready = 1'b0; dmem_rvalid = 1'b0;
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        if (is_load && !exp_mis) last_load = exp_load;
        else checkOutput("readdata_hold", ReadDataW, last_load);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int   req_cycles;
        logic berr_seen;
        rst_n = 1'b0;
        MemReadM = 0; MemWriteM = 0; Funct3M = 0; AluResultM = 0; WriteDataM = 0;
        dmem_req_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
        wd_read = 0; wd_f3 = 0; wd_addr = 0;
        #13;
        checkOutput("rst_readdata", ReadDataW, 32'h0);
        checkOutput("rst_stall", 32'(StallM), 32'h0);
        checkOutput("rst_req_valid", 32'(dmem_req_valid), 32'h0);
        checkOutput("rst_addr", dmem_addr, 32'h0);
        checkOutput("rst_wstrb", 32'(dmem_wstrb), 32'h0);
        checkOutput("rst_pulses", {29'b0, LoadValidW, MisalignM, BusErrM}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Loads from word 0x8000_F1A5 at earliest handshake timing
        applyStimulus(1, 0, F3_LB,  32'h103, 32'h0, 32'h8000F1A5, 0, 0, 32'h100, 32'h0, 4'h0, 32'hFFFFFF80, 4, 0);
        applyStimulus(1, 0, F3_LBU, 32'h103, 32'h0, 32'h8000F1A5, 0, 0, 32'h100, 32'h0, 4'h0, 32'h00000080, 4, 0);
        applyStimulus(1, 0, F3_LH,  32'h102, 32'h0, 32'h8000F1A5, 0, 0, 32'h100, 32'h0, 4'h0, 32'hFFFF8000, 4, 0);
        applyStimulus(1, 0, F3_LHU, 32'h100, 32'h0, 32'h8000F1A5, 0, 0, 32'h100, 32'h0, 4'h0, 32'h0000F1A5, 4, 0);
        applyStimulus(1, 0, F3_LW,  32'h100, 32'h0, 32'h8000F1A5, 0, 0, 32'h100, 32'h0, 4'h0, 32'h8000F1A5, 4, 0);
        // Stores
        applyStimulus(0, 1, F3_LB, 32'h101, 32'h12345678, 32'h0, 0, 0, 32'h100, 32'h78787878, 4'b0010, 32'h0, 3, 0);
        applyStimulus(0, 1, F3_LH, 32'h102, 32'h12345678, 32'h0, 0, 0, 32'h100, 32'h56785678, 4'b1100, 32'h0, 3, 0);
        applyStimulus(0, 1, F3_LW, 32'h104, 32'h12345678, 32'h0, 0, 0, 32'h104, 32'h12345678, 4'b1111, 32'h0, 3, 0);
        // Misaligned accesses
        applyStimulus(1, 0, F3_LW,  32'h102, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 2, 1);
        applyStimulus(0, 1, F3_LH,  32'h103, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 2, 1);
        applyStimulus(1, 0, F3_LHU, 32'h101, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 2, 1);
        // Read and write together act as a store
        applyStimulus(1, 1, F3_LW, 32'h108, 32'hAABBCCDD, 32'h0, 0, 0, 32'h108, 32'hAABBCCDD, 4'b1111, 32'h0, 3, 0);
        // Slow memory: ready after 5 cycles, rvalid after 3 more
        applyStimulus(1, 0, F3_LH, 32'h100, 32'h0, 32'h12348765, 5, 3, 32'h100, 32'h0, 4'h0, 32'hFFFF8765, 12, 0);
        applyStimulus(1, 0, F3_LB, 32'h101, 32'h0, 32'h00007F00, 0, 0, 32'h100, 32'h0, 4'h0, 32'h0000007F, 4, 0);
        applyStimulus(1, 0, 3'b011, 32'h10C, 32'h0, 32'hCAFEBABE, 0, 0, 32'h10C, 32'h0, 4'h0, 32'hCAFEBABE, 4, 0);

        // Watchdog: TIMEOUT=4 instance, ready never asserted
        @(posedge clk); #1;
        wd_read = 1'b1; wd_f3 = F3_LW; wd_addr = 32'h200;
        @(posedge clk); #1;
        wd_read = 1'b0;
        req_cycles = 0; berr_seen = 1'b0;
        for (int i = 0; i < 20 && !berr_seen; i++) begin
            @(negedge clk);
            if (wd_req_valid) req_cycles++;
            if (wd_buserr) begin
                berr_seen = 1'b1;
                checkOutput("wd_stall_done", 32'(wd_stall), 32'h0);
                checkOutput("wd_no_loadvalid", 32'(wd_loadvalid), 32'h0);
            end
        end
        checkOutput("wd_req_cycles", 32'(req_cycles), 32'd4);
        checkOutput("wd_buserr_seen", 32'(berr_seen), 32'h1);
        checkOutput("wd_readdata", wd_readdata, 32'h0);
        checkOutput("wd_addr", wd_dmem_addr, 32'h200);

        // Reset while waiting for rvalid
        @(posedge clk); #1;
        ev_push_reset_req();
        MemReadM = 1'b1; Funct3M = F3_LW; AluResultM = 32'h110; WriteDataM = 32'h0;
        @(posedge clk); #1;
        MemReadM = 1'b0;
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        @(negedge clk);
        checkOutput("wait_stall", 32'(StallM), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_req_valid", 32'(dmem_req_valid), 32'h0);
        checkOutput("arst_stall", 32'(StallM), 32'h0);
        checkOutput("arst_readdata", ReadDataW, 32'h0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("late_rvalid_loadvalid", 32'(LoadValidW), 32'h0);
        checkOutput("late_rvalid_readdata", ReadDataW, 32'h0);
        checkOutput("late_rvalid_stall", 32'(StallM), 32'h0);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic ev_push_reset_req();
        ev_t ev;
        ev.kind  = EV_REQ;
        ev.addr  = 32'h110;
        ev.we    = 1'b0;
        ev.wdata = 32'h0;
        ev.wstrb = 4'h0;
        ev.rdata = 32'h0;
        sb.push_back(ev);
    endtask

endmodule
